rob_multi_wb: RTL and testbench
===============================

Name: rob_multi_wb

Overview:
- Parametrised in-order-commit reorder buffer for the out-of-order RISC-V core; next generation of the single-EX/single-SLB ROB.
- Allocates tags at decode and accepts results from NUM_WB writeback channels.
- Retires one entry per cycle to the regfile or the store/load buffer.
- Raises a one-cycle flush with redirect PC when a committing branch was mispredicted.

Parameters:
- DEPTH, 16, entry count; power of two, >=4.
- NUM_WB, 2, number of writeback channels (EX, SLB, ...).
- DATA_W, 32, result width.
- ADDR_W, 32, PC width.
- REG_W, 5, architectural register index width.
- TAG_W, $clog2(DEPTH), tag width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- alloc_valid  in  1  decode requests an entry
- alloc_ready  out  1  entry available (combinational)
- alloc_tag  out  TAG_W  tag granted (= tail, combinational)
- alloc_rd  in  REG_W  destination register
- alloc_is_store  in  1  entry is SB/SH/SW
- alloc_is_br  in  1  entry is branch/JAL/JALR
- alloc_pred  in  1  predicted taken
- wb_valid  in  NUM_WB  per-channel result strobe
- wb_tag  in  NUM_WB*TAG_W  flattened tags
- wb_data  in  NUM_WB*DATA_W  flattened results
- wb_taken  in  NUM_WB  actual branch outcome
- wb_npc  in  NUM_WB*ADDR_W  correct next PC for branches
- cm_rf_en  out  1  regfile write pulse
- cm_rd  out  REG_W  regfile write index
- cm_data  out  DATA_W  regfile write data
- cm_tag  out  TAG_W  tag of retired entry (rename table release)
- cm_st_en  out  1  store release pulse to SLB
- cm_st_tag  out  TAG_W  tag of released store
- flush  out  1  misprediction flush pulse
- flush_pc  out  ADDR_W  redirect PC
- count  out  TAG_W+1  occupied entries

Behaviour:
- Reset: head=tail=0, count=0, all entries invalid. All outputs 0; alloc_ready=1 only once rst is low.
- rdy low: no state change; cm_rf_en, cm_st_en and flush forced 0 at the next edge.
- Allocate on alloc_valid && alloc_ready at the edge. Entry gets valid=1, done=0, the rd/store/br/pred fields; tail=(tail+1) mod DEPTH.
- alloc_ready = (count<DEPTH) && !flush. No allocate-through-commit bypass when full.
- Writeback: wb_valid[i] on a valid entry sets done=1 and latches data, taken and npc. Writeback to an invalid entry is ignored.
- Same-tag writeback on two channels in one cycle: highest channel index wins. This is illegal stimulus and is flagged by an assertion.
- Commit latency: writeback at edge N, commit pulse registered at edge N+1 when the entry is head. One retire per cycle, back-to-back allowed.
- Retire of a non-store: cm_rf_en=1 when rd!=0, with cm_rd, cm_data and cm_tag. cm_tag is driven even when rd=0.
- Retire of a store: cm_st_en=1 and cm_st_tag; cm_rf_en=0.
- In both cases the entry is invalidated and head advances.
- Branch retire with taken!=pred: retire normally (JALR/JAL write rd) and register flush=1, flush_pc=npc.
- Flush cycle: all entries invalidated, head=tail=0, count=0. Allocations and writebacks in that same edge are discarded.
- Correct branch: no flush.
- Count update: count += alloc − retire; simultaneous alloc and retire keeps count.
- Wrap-around: pointers wrap mod DEPTH; empty/full are derived from count, not from pointer equality.
- Mid-operation rst: identical to power-on reset, and overrides flush.

Optional Feature:
- ROB_SRC_FORWARD_EN: adds two operand lookup ports.
  - Inputs q0_tag/q1_tag (TAG_W); outputs q0_rdy/q1_rdy (1) and q0_data/q1_data (DATA_W).
  - Combinational: rdy=valid&&done, or any same-cycle wb_valid with matching tag (bypass, highest channel wins).
- Without the macro these ports and their logic are absent; dispatch waits for the regfile/CDB.

Decomposition:
- Shared package/header: TAG_W derivation function, Store/NotJump encodings, DataBus/AddrBus/NameBus widths, entry field bit offsets.
- One sub-module, rob_ptr_ctrl: head, tail and count registers with wrap, alloc/retire enables, and flush clear.

Test Plan:
- Reset then 16 allocs, no writeback -> tags 0..15, count=16, alloc_ready=0 on the 17th request.
- Alloc tags 0,1,2. Write back tag 2 then tag 0 (data 0xA0), then tag 1 (0xB1). Checks:
  - No commit until head tag 0 is done.
  - Then cm_rf_en on consecutive cycles: data 0xA0, 0xB1, then tag 2's data.
- Store at tag 3, written back via channel 1 -> cm_st_en=1, cm_st_tag=3, cm_rf_en=0.
- Branch pred=0, wb_taken=1, wb_npc=0x0000_1040, younger entries already allocated -> flush=1, flush_pc=0x1040, count=0 next cycle, younger writebacks ignored.
- Fill and drain 40 entries with interleaved alloc/retire -> tags wrap 15→0, in-order retire, count never exceeds 16.
- Hold rdy=0 three cycles with a done head -> no pulses, state frozen; retire resumes on the first rdy=1 edge.

Source files
------------

// File: rtl/rob_multi_wb_pkg.sv
// rob_multi_wb_pkg: shared widths, encodings and entry layout for the reorder buffer
package rob_multi_wb_pkg;
  localparam int DATA_BUS = 32;
  localparam int ADDR_BUS = 32;
  localparam int NAME_BUS = 5;
  localparam logic STORE = 1'b1;
  localparam logic NOT_JUMP = 1'b0;
  localparam int OFF_STORE = 0;
  localparam int OFF_BR = 1;
  localparam int OFF_PRED = 2;
  localparam int OFF_TAKEN = 3;
  localparam int OFF_RD = 4;
  function automatic int tag_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/rob_multi_wb_ptr_ctrl.sv
// rob_ptr_ctrl: head/tail/count bookkeeping with wrap and flush clear
module rob_ptr_ctrl #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             alloc_en,
  input  logic             retire_en,
  output logic [TAG_W-1:0] head,
  output logic [TAG_W-1:0] tail,
  output logic [TAG_W:0]   count
);
  always_ff @(posedge clk) begin
    if (rst || (rdy && flush)) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (rdy) begin
      if (alloc_en) tail <= tail + TAG_W'(1);
      if (retire_en) head <= head + TAG_W'(1);
      count <= count + (TAG_W+1)'(alloc_en) - (TAG_W+1)'(retire_en);
    end
  end
endmodule

// File: rtl/rob_multi_wb.sv
// rob_multi_wb: in-order-commit ROB with NUM_WB writeback channels; ROB_SRC_FORWARD_EN adds operand lookup ports
module rob_multi_wb
  import rob_multi_wb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int NUM_WB = 2,
  parameter int DATA_W = DATA_BUS,
  parameter int ADDR_W = ADDR_BUS,
  parameter int REG_W = NAME_BUS,
  parameter int TAG_W = tag_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic [REG_W-1:0]         alloc_rd,
  input  logic                     alloc_is_store,
  input  logic                     alloc_is_br,
  input  logic                     alloc_pred,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]  wb_tag,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB-1:0]        wb_taken,
  input  logic [NUM_WB*ADDR_W-1:0] wb_npc,
  output logic                     cm_rf_en,
  output logic [REG_W-1:0]         cm_rd,
  output logic [DATA_W-1:0]        cm_data,
  output logic [TAG_W-1:0]         cm_tag,
  output logic                     cm_st_en,
  output logic [TAG_W-1:0]         cm_st_tag,
  output logic                     flush,
  output logic [ADDR_W-1:0]        flush_pc,
  output logic [TAG_W:0]           count
`ifdef ROB_SRC_FORWARD_EN
  ,
  input  logic [TAG_W-1:0]         q0_tag,
  input  logic [TAG_W-1:0]         q1_tag,
  output logic                     q0_rdy,
  output logic                     q1_rdy,
  output logic [DATA_W-1:0]        q0_data,
  output logic [DATA_W-1:0]        q1_data
`endif
);
  localparam int META_W = OFF_RD + REG_W;
  logic [DEPTH-1:0]  e_valid, e_done;
  logic [META_W-1:0] e_meta [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];
  logic [ADDR_W-1:0] e_npc [DEPTH];
  logic [TAG_W-1:0]  wt [NUM_WB];
  logic [DATA_W-1:0] wd [NUM_WB];
  logic [ADDR_W-1:0] wn [NUM_WB];
  logic [TAG_W-1:0]  head, tail;
  logic [META_W-1:0] hm;
  logic alloc_en, retire_en, mispredict, dup_wb;
  for (genvar w = 0; w < NUM_WB; w++) begin : g_unpack
    assign wt[w] = wb_tag[w*TAG_W +: TAG_W];
    assign wd[w] = wb_data[w*DATA_W +: DATA_W];
    assign wn[w] = wb_npc[w*ADDR_W +: ADDR_W];
  end
  assign hm = e_meta[head];
  assign alloc_ready = !rst && count < (TAG_W+1)'(DEPTH) && !flush;
  assign alloc_tag = tail;
  assign alloc_en = rdy && alloc_valid && alloc_ready;
  assign retire_en = rdy && !flush && e_valid[head] && e_done[head];
  assign mispredict = hm[OFF_BR] != NOT_JUMP && hm[OFF_TAKEN] != hm[OFF_PRED];
  rob_ptr_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_ptr (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .alloc_en(alloc_en), .retire_en(retire_en),
    .head(head), .tail(tail), .count(count)
  );
  // later channels overwrite earlier ones, so the highest index wins on a tag clash
  always_ff @(posedge clk) begin
    if (rst || (rdy && flush)) begin
      e_valid <= '0;
      e_done <= '0;
    end else if (rdy) begin
      if (alloc_en) begin
        e_valid[tail] <= 1'b1;
        e_done[tail] <= 1'b0;
        e_meta[tail] <= {alloc_rd, 1'b0, alloc_pred, alloc_is_br, alloc_is_store};
      end
      for (int i = 0; i < NUM_WB; i++)
        if (wb_valid[i] && e_valid[wt[i]]) begin
          e_done[wt[i]] <= 1'b1;
          e_data[wt[i]] <= wd[i];
          e_npc[wt[i]] <= wn[i];
          e_meta[wt[i]][OFF_TAKEN] <= wb_taken[i];
        end
      if (retire_en) e_valid[head] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cm_rf_en <= 1'b0;
      cm_rd <= '0;
      cm_data <= '0;
      cm_tag <= '0;
      cm_st_en <= 1'b0;
      cm_st_tag <= '0;
      flush <= 1'b0;
      flush_pc <= '0;
    end else if (!rdy) begin
      cm_rf_en <= 1'b0;
      cm_st_en <= 1'b0;
      flush <= 1'b0;
    end else begin
      cm_rf_en <= retire_en && hm[OFF_STORE] != STORE && hm[OFF_RD +: REG_W] != '0;
      cm_st_en <= retire_en && hm[OFF_STORE] == STORE;
      flush <= retire_en && mispredict;
      if (retire_en) begin
        cm_rd <= hm[OFF_RD +: REG_W];
        cm_data <= e_data[head];
        cm_tag <= head;
      end
      if (retire_en && hm[OFF_STORE] == STORE) cm_st_tag <= head;
      if (retire_en && mispredict) flush_pc <= e_npc[head];
    end
  end
  always_comb begin
    dup_wb = 1'b0;
    for (int i = 0; i < NUM_WB; i++)
      for (int j = i + 1; j < NUM_WB; j++)
        dup_wb = dup_wb | (wb_valid[i] && wb_valid[j] && wt[i] == wt[j]);
  end
  assert property (@(posedge clk) disable iff (rst) !dup_wb);
`ifdef ROB_SRC_FORWARD_EN
  always_comb begin
    q0_rdy = e_valid[q0_tag] && e_done[q0_tag];
    q0_data = e_data[q0_tag];
    q1_rdy = e_valid[q1_tag] && e_done[q1_tag];
    q1_data = e_data[q1_tag];
    for (int i = 0; i < NUM_WB; i++) begin
      if (wb_valid[i] && wt[i] == q0_tag) begin
        q0_rdy = 1'b1;
        q0_data = wd[i];
      end
      if (wb_valid[i] && wt[i] == q1_tag) begin
        q1_rdy = 1'b1;
        q1_data = wd[i];
      end
    end
  end
`endif
endmodule

// File: tb/tb_rob_multi_wb.sv
// tb_rob_multi_wb: vector table, directed corner sequences and a queue-model random run for rob_multi_wb
module tb_rob_multi_wb;
  localparam int TAG_W = 4;
  logic clk = 0, rst = 1, rdy = 1;
  logic alloc_valid = 0, alloc_ready, alloc_is_store = 0, alloc_is_br = 0, alloc_pred = 0;
  logic [TAG_W-1:0] alloc_tag;
  logic [4:0] alloc_rd = 0;
  logic [1:0] wb_valid = 0, wb_taken = 0;
  logic [7:0] wb_tag = 0;
  logic [63:0] wb_data = 0, wb_npc = 0;
  logic cm_rf_en, cm_st_en, flush;
  logic [4:0] cm_rd;
  logic [31:0] cm_data, flush_pc;
  logic [TAG_W-1:0] cm_tag, cm_st_tag;
  logic [TAG_W:0] count;
`ifdef ROB_SRC_FORWARD_EN
  logic [TAG_W-1:0] q0_tag = 0, q1_tag = 0;
  logic q0_rdy, q1_rdy;
  logic [31:0] q0_data, q1_data;
`endif
  int n_chk = 0, n_pass = 0;
  rob_multi_wb dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .alloc_rd(alloc_rd), .alloc_is_store(alloc_is_store), .alloc_is_br(alloc_is_br), .alloc_pred(alloc_pred),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_taken(wb_taken), .wb_npc(wb_npc),
    .cm_rf_en(cm_rf_en), .cm_rd(cm_rd), .cm_data(cm_data), .cm_tag(cm_tag),
    .cm_st_en(cm_st_en), .cm_st_tag(cm_st_tag), .flush(flush), .flush_pc(flush_pc), .count(count)
`ifdef ROB_SRC_FORWARD_EN
    , .q0_tag(q0_tag), .q1_tag(q1_tag), .q0_rdy(q0_rdy), .q1_rdy(q1_rdy), .q0_data(q0_data), .q1_data(q1_data)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [4:0] rd; logic st, br, pred, taken; int ch;
    logic [31:0] data, npc; logic e_rf, e_st, e_fl;
  } vec_t;
  typedef struct {logic [3:0] tag; logic [4:0] rd; logic st, done; logic [31:0] data;} ent_t;
  vec_t tbl [7];
  ent_t q [$];
  ent_t hd;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_in();
    alloc_valid = 0; alloc_rd = 0; alloc_is_store = 0; alloc_is_br = 0; alloc_pred = 0;
    wb_valid = 0; wb_taken = 0;
  endtask
  task automatic do_reset();
    clear_in();
    rst = 1;
    tick();
    tick();
    rst = 0;
    #1;
  endtask
  task automatic alloc(input logic [4:0] rd, input logic st, input logic br, input logic pred);
    alloc_valid = 1; alloc_rd = rd; alloc_is_store = st; alloc_is_br = br; alloc_pred = pred;
  endtask
  task automatic wb(input int ch, input logic [3:0] tag, input logic [31:0] data, input logic taken, input logic [31:0] npc);
    wb_valid[ch] = 1;
    wb_tag[ch*TAG_W +: TAG_W] = tag;
    wb_data[ch*32 +: 32] = data;
    wb_taken[ch] = taken;
    wb_npc[ch*32 +: 32] = npc;
  endtask
  initial begin
    logic [3:0] nt, t;
    logic [3:0] wtag [2];
    logic [31:0] wdat [2];
    logic wv [2];
    logic r, acc, ok;
    int k;
    tbl[0] = '{5'd5, 0, 0, 0, 0, 0, 32'h1111_1111, 32'h0, 1, 0, 0};
    tbl[1] = '{5'd0, 0, 0, 0, 0, 1, 32'h0000_0022, 32'h0, 0, 0, 0};
    tbl[2] = '{5'd4, 1, 0, 0, 0, 1, 32'h0000_0033, 32'h0, 0, 1, 0};
    tbl[3] = '{5'd0, 0, 1, 1, 1, 0, 32'h0000_0044, 32'h0000_0100, 0, 0, 0};
    tbl[4] = '{5'd1, 0, 1, 1, 0, 1, 32'h0000_0055, 32'h0000_2000, 1, 0, 1};
    tbl[5] = '{5'd0, 0, 1, 0, 0, 0, 32'h0000_0066, 32'h0000_0300, 0, 0, 0};
    tbl[6] = '{5'd31, 0, 0, 0, 0, 1, 32'hdead_beef, 32'h0, 1, 0, 0};
    tick();
    chk("rst_ready", alloc_ready, 0);
    chk("rst_count", count, 0);
    chk("rst_pulses", {cm_rf_en, cm_st_en, flush}, 0);
    chk("rst_cm_data", cm_data, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", alloc_ready, 1);
    chk("tag_after_rst", alloc_tag, 0);
    for (int i = 0; i < 16; i++) begin
      alloc(5'(i + 1), 0, 0, 0);
      chk("fill_tag", alloc_tag, i);
      tick();
    end
    chk("full_count", count, 16);
    chk("full_ready", alloc_ready, 0);
    tick();
    chk("full_17th_rejected", count, 16);
    clear_in();
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("midop_rst_count", count, 0);
    chk("midop_rst_tag", alloc_tag, 0);
    chk("midop_rst_ready", alloc_ready, 1);
    alloc(1, 0, 0, 0); tick();
    alloc(2, 0, 0, 0); tick();
    alloc(3, 0, 0, 0); tick();
    clear_in();
    wb(0, 2, 32'hC2, 0, 0); tick(); clear_in();
    chk("no_commit_t2_only", cm_rf_en, 0);
    wb(1, 0, 32'hA0, 0, 0); tick(); clear_in();
    chk("no_commit_same_edge", cm_rf_en, 0);
    wb(0, 1, 32'hB1, 0, 0); tick(); clear_in();
    chk("ooo_c0_en", cm_rf_en, 1);
    chk("ooo_c0_data", cm_data, 32'hA0);
    chk("ooo_c0_tag", cm_tag, 0);
    tick();
    chk("ooo_c1_en", cm_rf_en, 1);
    chk("ooo_c1_data", cm_data, 32'hB1);
    tick();
    chk("ooo_c2_en", cm_rf_en, 1);
    chk("ooo_c2_data", cm_data, 32'hC2);
    chk("ooo_c2_rd", cm_rd, 3);
    tick();
    chk("ooo_idle", cm_rf_en, 0);
    chk("ooo_count", count, 0);
    alloc(9, 1, 0, 0);
    chk("store_tag", alloc_tag, 3);
    tick(); clear_in();
    wb(1, 3, 32'h55, 0, 0); tick(); clear_in();
    tick();
    chk("store_st_en", cm_st_en, 1);
    chk("store_st_tag", cm_st_tag, 3);
    chk("store_rf_en", cm_rf_en, 0);
    tick();
    chk("store_pulse_end", cm_st_en, 0);
    alloc(1, 0, 1, 0); tick();
    alloc(6, 0, 0, 0); tick();
    alloc(7, 0, 0, 0); tick();
    clear_in();
    wb(0, 4, 32'h44, 1, 32'h0000_1040);
    wb(1, 5, 32'h55, 0, 0);
    tick(); clear_in();
    tick();
    chk("br_flush", flush, 1);
    chk("br_flush_pc", flush_pc, 32'h1040);
    chk("br_link_en", cm_rf_en, 1);
    chk("br_link_data", cm_data, 32'h44);
    chk("br_count_pre", count, 2);
    chk("br_ready_in_flush", alloc_ready, 0);
    alloc(3, 0, 0, 0);
    wb(0, 6, 32'h66, 0, 0);
    tick(); clear_in();
    chk("br_flush_pulse", flush, 0);
    chk("br_count_post", count, 0);
    chk("br_tag_post", alloc_tag, 0);
    chk("br_no_young_retire", cm_rf_en, 0);
    tick();
    chk("br_still_empty", {cm_rf_en, count}, 0);
    do_reset();
    nt = 0;
    foreach (tbl[i]) begin
      alloc(tbl[i].rd, tbl[i].st, tbl[i].br, tbl[i].pred);
      chk("vec_tag", alloc_tag, nt);
      tick(); clear_in();
      wb(tbl[i].ch, nt, tbl[i].data, tbl[i].taken, tbl[i].npc);
      tick(); clear_in();
      tick();
      chk("vec_rf_en", cm_rf_en, tbl[i].e_rf);
      chk("vec_st_en", cm_st_en, tbl[i].e_st);
      chk("vec_flush", flush, tbl[i].e_fl);
      chk("vec_cm_tag", cm_tag, nt);
      if (tbl[i].e_rf) chk("vec_data", {cm_rd, cm_data}, {tbl[i].rd, tbl[i].data});
      if (tbl[i].e_st) chk("vec_st_tag", cm_st_tag, nt);
      if (tbl[i].e_fl) begin
        chk("vec_flush_pc", flush_pc, tbl[i].npc);
        tick();
        chk("vec_flush_count", count, 0);
        nt = 0;
      end else nt = nt + 4'd1;
    end
    do_reset();
    alloc(8, 0, 0, 0); tick(); clear_in();
    wb(0, 0, 32'h88, 0, 0); tick(); clear_in();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_no_pulse", {cm_rf_en, cm_st_en, flush}, 0);
      chk("hold_count", count, 1);
    end
    rdy = 1;
    tick();
    chk("hold_resume_en", cm_rf_en, 1);
    chk("hold_resume_data", cm_data, 32'h88);
    chk("hold_resume_count", count, 0);
    do_reset();
    nt = 0;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      clear_in();
      rdy = ($urandom_range(9) != 0);
      chk("rnd_ready", alloc_ready, q.size() < 16);
      chk("rnd_alloc_tag", alloc_tag, nt);
      for (int ch = 0; ch < 2; ch++) begin
        wv[ch] = 0;
        if ($urandom_range(3) != 0) begin
          if (q.size() > 0 && $urandom_range(7) != 0) begin
            k = $urandom_range(q.size() - 1);
            t = q[k].tag;
            ok = !q[k].done;
          end else begin
            t = nt;
            ok = q.size() < 16;
          end
          if (ok && !(ch == 1 && wv[0] && wtag[0] == t)) begin
            wv[ch] = 1;
            wtag[ch] = t;
            wdat[ch] = $urandom;
            wb(ch, t, wdat[ch], 0, 0);
          end
        end
      end
      if ($urandom_range(2) != 0) alloc(5'($urandom), 1'($urandom), 0, 0);
      r = rdy && q.size() > 0 && q[0].done;
      if (r) hd = q[0];
      acc = rdy && alloc_valid && q.size() < 16;
      if (rdy)
        for (int ch = 0; ch < 2; ch++)
          if (wv[ch])
            foreach (q[j])
              if (q[j].tag == wtag[ch]) begin
                q[j].done = 1;
                q[j].data = wdat[ch];
              end
      if (r) void'(q.pop_front());
      if (acc) begin
        q.push_back('{nt, alloc_rd, alloc_is_store, 1'b0, 32'h0});
        nt = nt + 4'd1;
      end
      tick();
      chk("rnd_rf_en", cm_rf_en, r && !hd.st && hd.rd != 0);
      chk("rnd_st_en", cm_st_en, r && hd.st);
      if (r && !hd.st) chk("rnd_commit", {cm_tag, cm_rd, cm_data}, {hd.tag, hd.rd, hd.data});
      if (r && hd.st) chk("rnd_st_tag", cm_st_tag, hd.tag);
      chk("rnd_count", count, q.size());
    end
    clear_in();
    rdy = 1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
